// File: rtl/tlb_maint_if.sv
// Request/response channel between the CP0/exception stage (master) and the TLB maintenance unit (slave).
interface tlb_maint_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] index_i;
    logic [31:0] entryhi_i;
    logic [31:0] entrylo0_i;
    logic [31:0] entrylo1_i;
    logic [31:0] pagemask_i;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_op;
    logic [31:0] index_o;
    logic [31:0] entryhi_o;
    logic [31:0] entrylo0_o;
    logic [31:0] entrylo1_o;
    logic [31:0] pagemask_o;

    modport master (
        output req_valid, req_op, index_i, entryhi_i, entrylo0_i, entrylo1_i, pagemask_i, resp_ready,
        input  req_ready, resp_valid, resp_op, index_o, entryhi_o, entrylo0_o, entrylo1_o, pagemask_o
    );

    modport slave (
        input  req_valid, req_op, index_i, entryhi_i, entrylo0_i, entrylo1_i, pagemask_i, resp_ready,
        output req_ready, resp_valid, resp_op, index_o, entryhi_o, entrylo0_o, entrylo1_o, pagemask_o
    );
endinterface

// File: rtl/tlb_maint_unit.sv
// Joint-TLB maintenance unit: TLBWI / TLBR / TLBP (one entry per cycle) and the entry array.
// Optional macro TLB_RANDOM_EN turns op 00 into TLBWR using an internal Random counter.
module tlb_maint_unit #(
    parameter int unsigned TLB_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    tlb_maint_if.slave                  bus,
    output logic [TLB_ENTRIES*90-1:0]   tlb_flat_o
);
    localparam int unsigned ENT_W = 90;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_PROBE, S_RESP} state_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic [11:0] mask;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    state_e             state_q, state_d;
    tlb_entry_t         entries_q [TLB_ENTRIES];
    logic [1:0]         resp_op_q;
    logic [18:0]        vpn2_q;
    logic [7:0]         asid_q;
    logic [11:0]        mask_q;
    logic [25:0]        lo0_q, lo1_q;
    logic [IDX_W-1:0]   widx_q;
    logic [IDX_W-1:0]   cnt_q;
    logic               cmp_vld_q, cmp_hit_q;
    logic [IDX_W-1:0]   cmp_idx_q;
    logic [31:0]        idx_res_q, hi_res_q, lo0_res_q, lo1_res_q, pm_res_q;
    tlb_entry_t         wr_entry, rd_entry, pr_entry;
    logic               pr_match_c, probe_done_c;

`ifdef TLB_RANDOM_EN
    logic [IDX_W-1:0]   random_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) random_q <= IDX_W'(TLB_ENTRIES - 1);
        else     random_q <= random_q - IDX_W'(1);
    end
`endif

    assign wr_entry = '{vpn2: vpn2_q, asid: asid_q, mask: mask_q, g: lo0_q[0] & lo1_q[0],
                        pfn0: lo0_q[25:6], c0: lo0_q[5:3], d0: lo0_q[2], v0: lo0_q[1],
                        pfn1: lo1_q[25:6], c1: lo1_q[5:3], d1: lo1_q[2], v1: lo1_q[1]};
    assign rd_entry = entries_q[widx_q];
    assign pr_entry = entries_q[cnt_q];
    assign pr_match_c = (pr_entry.vpn2 == vpn2_q) && ((pr_entry.asid == asid_q) || pr_entry.g);
    // Compare results are registered, so the decision trails the scanned index by one cycle.
    assign probe_done_c = cmp_vld_q && (cmp_hit_q || (cmp_idx_q == IDX_W'(TLB_ENTRIES - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                case (bus.req_op)
                    2'b01:   state_d = S_WRITE;
                    2'b10:   state_d = S_READ;
                    2'b11:   state_d = S_PROBE;
`ifdef TLB_RANDOM_EN
                    default: state_d = S_WRITE;
`else
                    default: state_d = S_RESP;
`endif
                endcase
            end
            S_WRITE, S_READ: state_d = S_RESP;
            S_PROBE: if (probe_done_c) state_d = S_RESP;
            S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        case (state_q)
            S_IDLE:  bus.req_ready  = 1'b1;
            S_RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
        bus.resp_op    = resp_op_q;
        bus.index_o    = idx_res_q;
        bus.entryhi_o  = hi_res_q;
        bus.entrylo0_o = lo0_res_q;
        bus.entrylo1_o = lo1_res_q;
        bus.pagemask_o = pm_res_q;
    end

    // Operand latch, read/probe results and the probe scan pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_op_q <= '0;
            vpn2_q    <= '0;
            asid_q    <= '0;
            mask_q    <= '0;
            lo0_q     <= '0;
            lo1_q     <= '0;
            widx_q    <= '0;
            cnt_q     <= '0;
            cmp_vld_q <= 1'b0;
            cmp_hit_q <= 1'b0;
            cmp_idx_q <= '0;
            idx_res_q <= '0;
            hi_res_q  <= '0;
            lo0_res_q <= '0;
            lo1_res_q <= '0;
            pm_res_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.req_valid) begin
                    resp_op_q <= bus.req_op;
                    vpn2_q    <= bus.entryhi_i[31:13];
                    asid_q    <= bus.entryhi_i[7:0];
                    mask_q    <= bus.pagemask_i[24:13];
                    lo0_q     <= bus.entrylo0_i[25:0];
                    lo1_q     <= bus.entrylo1_i[25:0];
                    widx_q    <= bus.index_i[IDX_W-1:0];
`ifdef TLB_RANDOM_EN
                    if (bus.req_op == 2'b00) widx_q <= random_q;
`endif
                    cnt_q     <= '0;
                    cmp_vld_q <= 1'b0;
                    idx_res_q <= '0;
                    hi_res_q  <= '0;
                    lo0_res_q <= '0;
                    lo1_res_q <= '0;
                    pm_res_q  <= '0;
                end
                S_WRITE: begin
`ifdef TLB_RANDOM_EN
                    if (resp_op_q == 2'b00) idx_res_q <= 32'(widx_q);
`endif
                end
                S_READ: begin
                    hi_res_q  <= {rd_entry.vpn2, 5'b0, rd_entry.asid};
                    lo0_res_q <= {6'b0, rd_entry.pfn0, rd_entry.c0, rd_entry.d0, rd_entry.v0, rd_entry.g};
                    lo1_res_q <= {6'b0, rd_entry.pfn1, rd_entry.c1, rd_entry.d1, rd_entry.v1, rd_entry.g};
                    pm_res_q  <= {7'b0, rd_entry.mask, 13'b0};
                end
                S_PROBE: begin
                    cnt_q     <= cnt_q + IDX_W'(1);
                    cmp_vld_q <= 1'b1;
                    cmp_hit_q <= pr_match_c;
                    cmp_idx_q <= cnt_q;
                    if (probe_done_c)
                        idx_res_q <= cmp_hit_q ? 32'(cmp_idx_q) : 32'h8000_0000;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) entries_q[i] <= '0;
        end else if (state_q == S_WRITE) begin
            entries_q[widx_q] <= wr_entry;
        end
    end

    always_comb begin
        tlb_flat_o = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) tlb_flat_o[i*ENT_W +: ENT_W] = entries_q[i];
    end
endmodule

// File: tb/tb_tlb_maint_unit.sv
// Directed bench for tlb_maint_unit: field-level TLB model, per-cycle compare process, literal pins.
module tb_tlb_maint_unit;
    localparam int unsigned N  = 16;
    localparam int unsigned EW = 90;

    logic clk;
    logic rst;
    logic [N*EW-1:0] flat;

    tlb_maint_if bus ();

    tlb_maint_unit #(.TLB_ENTRIES(N), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .tlb_flat_o(flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: entry fields as the architecture defines them
    logic [18:0] m_vpn2 [N];
    logic [7:0]  m_asid [N];
    logic [11:0] m_mask [N];
    logic        m_g    [N];
    logic [24:0] m_l0   [N];
    logic [24:0] m_l1   [N];

    logic        chk_en, exp_ready, exp_valid;
    logic [1:0]  exp_op;
    logic [31:0] exp_idx, exp_hi, exp_l0, exp_l1, exp_pm;
    int          cap_lat;
    logic [31:0] cap_idx, cap_hi, cap_l0, cap_l1, cap_pm;

`ifdef TLB_RANDOM_EN
    logic [3:0] m_rnd;
    always @(posedge clk or posedge rst) begin
        if (rst) m_rnd <= 4'd15;
        else     m_rnd <= m_rnd - 4'd1;
    end
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_flat(input string name, input logic [N*EW-1:0] act, input logic [N*EW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < N; i++) begin
                if (act[i*EW +: EW] !== exp[i*EW +: EW]) begin
                    $display("FAIL %s: entry %0d got %0h expected %0h at %0t",
                             name, i, act[i*EW +: EW], exp[i*EW +: EW], $time);
                    break;
                end
            end
        end
    endtask

    task automatic m_clear();
        for (int i = 0; i < N; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_mask[i] = '0;
            m_g[i] = 1'b0; m_l0[i] = '0; m_l1[i] = '0;
        end
    endtask

    task automatic m_write(input int i, input logic [31:0] hi, lo0, lo1, pm);
        m_vpn2[i] = hi[31:13];
        m_asid[i] = hi[7:0];
        m_mask[i] = pm[24:13];
        m_g[i]    = lo0[0] & lo1[0];
        m_l0[i]   = lo0[25:1];
        m_l1[i]   = lo1[25:1];
    endtask

    function automatic logic [N*EW-1:0] m_flat();
        logic [N*EW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++)
            f[i*EW +: EW] = {m_vpn2[i], m_asid[i], m_mask[i], m_g[i], m_l0[i], m_l1[i]};
        return f;
    endfunction

    function automatic int m_probe(input logic [31:0] hi);
        for (int i = 0; i < N; i++)
            if (m_vpn2[i] == hi[31:13] && (m_asid[i] == hi[7:0] || m_g[i])) return i;
        return -1;
    endfunction

    // Compare process: every cycle, outputs against the model's expectations
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("req_ready", 128'(bus.req_ready), 128'(exp_ready));
            chk("resp_valid", 128'(bus.resp_valid), 128'(exp_valid));
            chk_flat("tlb_flat", flat, m_flat());
            if (exp_valid) begin
                chk("resp_op", 128'(bus.resp_op), 128'(exp_op));
                chk("index_o", 128'(bus.index_o), 128'(exp_idx));
                chk("entryhi_o", 128'(bus.entryhi_o), 128'(exp_hi));
                chk("entrylo0_o", 128'(bus.entrylo0_o), 128'(exp_l0));
                chk("entrylo1_o", 128'(bus.entrylo1_o), 128'(exp_l1));
                chk("pagemask_o", 128'(bus.pagemask_o), 128'(exp_pm));
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"}, 128'(bus.req_ready), 128'(1));
        chk({tag, "_valid"}, 128'(bus.resp_valid), 128'(0));
        chk({tag, "_op"}, 128'(bus.resp_op), 128'(0));
        chk({tag, "_results"}, {bus.index_o, bus.entryhi_o, bus.entrylo0_o, bus.entrylo1_o | bus.pagemask_o}, 128'(0));
        chk_flat({tag, "_flat"}, flat, '0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] idx, hi, lo0, lo1, pm,
                         input int hold, input int rst_at);
        int lat, hit;
        int widx;
        logic wr;
        @(negedge clk);
        bus.req_op = op; bus.index_i = idx; bus.entryhi_i = hi;
        bus.entrylo0_i = lo0; bus.entrylo1_i = lo1; bus.pagemask_i = pm;
        bus.req_valid = 1'b1;
        widx = int'(idx[3:0]);
        wr = (op == 2'b01);
`ifdef TLB_RANDOM_EN
        if (op == 2'b00) begin widx = int'(m_rnd); wr = 1'b1; end
`endif
        exp_op = op; exp_idx = '0; exp_hi = '0; exp_l0 = '0; exp_l1 = '0; exp_pm = '0;
        lat = 0;
        case (op)
            2'b01: lat = 1;
            2'b10: begin
                lat = 1;
                exp_hi = {m_vpn2[widx], 5'b0, m_asid[widx]};
                exp_l0 = {6'b0, m_l0[widx], m_g[widx]};
                exp_l1 = {6'b0, m_l1[widx], m_g[widx]};
                exp_pm = {7'b0, m_mask[widx], 13'b0};
            end
            2'b11: begin
                hit = m_probe(hi);
                lat = (hit >= 0) ? hit + 2 : N + 1;
                exp_idx = (hit >= 0) ? 32'(hit) : 32'h8000_0000;
            end
            default: if (wr) begin lat = 1; exp_idx = 32'(widx); end
        endcase
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.index_i = ~idx; bus.entryhi_i = ~hi; bus.entrylo0_i = ~lo0;
        bus.entrylo1_i = ~lo1; bus.pagemask_i = ~pm;
        exp_ready = 1'b0;
        cap_lat = bus.resp_valid ? 0 : -1;
        for (int n = 0; n < lat; n++) begin
            if (n == rst_at) begin
                #1 rst = 1'b1;
                #1;
                m_clear();
                reset_checks("midrst");
                exp_ready = 1'b1;
                exp_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (n == 0 && wr) m_write(widx, hi, lo0, lo1, pm);
            if (cap_lat < 0 && bus.resp_valid) cap_lat = n + 1;
        end
        exp_valid = 1'b1;
        cap_idx = bus.index_o; cap_hi = bus.entryhi_o; cap_l0 = bus.entrylo0_o;
        cap_l1 = bus.entrylo1_o; cap_pm = bus.pagemask_o;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    logic [89:0] e3;

    initial begin
        chk_en = 1'b0; exp_ready = 1'b1; exp_valid = 1'b0; exp_op = '0;
        exp_idx = '0; exp_hi = '0; exp_l0 = '0; exp_l1 = '0; exp_pm = '0;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.index_i = '0; bus.entryhi_i = '0;
        bus.entrylo0_i = '0; bus.entrylo1_i = '0; bus.pagemask_i = '0; bus.resp_ready = 1'b0;
        m_clear();
        rst = 1'b1;
        #12;
        reset_checks("reset");
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // TLBWI entry 3, then pin its packed layout
        issue(2'b01, 32'd3, 32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0, 0, -1);
        e3 = {19'h00201, 8'h05, 12'h0, 1'b1, 20'h00041, 5'b00011, 20'h00042, 5'b00011};
        chk("entry3_layout", 128'(flat[3*EW +: EW]), 128'(e3));

        issue(2'b10, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("tlbr3", {cap_hi, cap_l0, cap_l1, cap_pm},
            {32'h0040_2005, 32'h0000_1047, 32'h0000_1087, 32'h0});

        issue(2'b11, 32'd0, 32'h0040_2009, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("probe_g_idx", 128'(cap_idx), 128'(3));
        chk("probe_g_lat", 128'(cap_lat), 128'(5));

        issue(2'b11, 32'd0, 32'h0080_0005, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("probe_miss_idx", 128'(cap_idx), 128'(32'h8000_0000));
        chk("probe_miss_lat", 128'(cap_lat), 128'(17));

        // Index 18 aliases to entry 2; entries 2 and 5 both match the same VPN2/ASID
        issue(2'b01, 32'd18, 32'h1234_6011, 32'h2000_0006, 32'h0000_00c2, 32'h0000_6000, 0, -1);
        issue(2'b01, 32'd5, 32'h1234_6011, 32'h0000_3ffe, 32'h0000_0002, 32'h0, 0, -1);
        issue(2'b10, 32'd2, 32'h0, 32'h0, 32'h0, 32'h0, 0, -1);
        chk("tlbr2", {cap_hi, cap_l0, cap_l1, cap_pm},
            {32'h1234_6011, 32'h0000_0006, 32'h0000_00c2, 32'h0000_6000});

        issue(2'b11, 32'd0, 32'h1234_6011, 32'h0, 32'h0, 32'h0, 4, -1);
        chk("probe_lowest_idx", 128'(cap_idx), 128'(2));
        chk("probe_lowest_lat", 128'(cap_lat), 128'(4));

        issue(2'b10, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 2, -1);
        issue(2'b11, 32'd0, 32'h1234_6022, 32'h0, 32'h0, 32'h0, 0, -1);

        // Reset lands during a long (missing) probe
        issue(2'b11, 32'd0, 32'h0080_0005, 32'h0, 32'h0, 32'h0, 0, 6);

        repeat (20) @(posedge clk);
        issue(2'b00, 32'd7, 32'h0ABC_E033, 32'h0000_0045, 32'h0000_0083, 32'h0, 0, -1);
`ifdef TLB_RANDOM_EN
        chk("tlbwr_idx", 128'(cap_idx), 128'(11));
        chk("tlbwr_entry11", 128'(flat[11*EW +: EW]),
            128'({19'h055E7, 8'h33, 12'h0, 1'b1, 25'h22, 25'h41}));
`else
        chk("nop_idx", 128'(cap_idx), 128'(0));
        chk_flat("nop_flat", flat, '0);
`endif

        issue(2'b11, 32'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1, -1);
        chk("probe_after_rst", 128'(cap_idx), 128'(0));
        chk("probe_after_rst_lat", 128'(cap_lat), 128'(2));

        @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/tlb_maint_unit.md
Name: tlb_maint_unit

Overview:
- Write/read/probe side of the joint TLB. Executes TLBWI, TLBR and TLBP issued by the CP0/exception stage.
- Owns the TLB entry array and drives it, packed, to the instruction and data lookup translators.
- Multi-cycle: TLBP scans one entry per cycle. Request/response handshake with the pipeline.

Parameters:
- TLB_ENTRIES, 16, number of entries; power of two, minimum 2.
- IDX_W, 4, index width, equal to log2(TLB_ENTRIES).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  operation request
- req_ready  out  1  unit idle, can accept
- req_op  in  2  01 TLBWI, 10 TLBR, 11 TLBP, 00 NOP/TLBWR (see Optional Feature)
- index_i  in  32  CP0 Index; only [IDX_W-1:0] used
- entryhi_i  in  32  CP0 EntryHi
- entrylo0_i  in  32  CP0 EntryLo0
- entrylo1_i  in  32  CP0 EntryLo1
- pagemask_i  in  32  CP0 PageMask
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumed
- resp_op  out  2  op of this result
- index_o  out  32  TLBP result
- entryhi_o  out  32  TLBR result
- entrylo0_o  out  32  TLBR result
- entrylo1_o  out  32  TLBR result
- pagemask_o  out  32  TLBR result
- tlb_flat_o  out  TLB_ENTRIES*90  entry i at [i*90+89:i*90]

Behaviour:
- Entry format (90b):
  - [89:71] VPN2, [70:63] ASID, [62:51] Mask, [50] G
  - [49:30] PFN0, [29:27] C0, [26] D0, [25] V0
  - [24:5] PFN1, [4:2] C1, [1] D1, [0] V1
- States: IDLE, WRITE, READ, PROBE, RESP.
- req_ready = (state==IDLE).
- Accept on req_valid & req_ready: latch op and all five CP0 inputs. Next state:
  - 01 -> WRITE
  - 10 -> READ
  - 11 -> PROBE, scan counter = 0
  - 00 -> RESP, all results zero
- WRITE (1 cycle):
  - entry[idx] <= {hi[31:13], hi[7:0], pm[24:13], lo0[0]&lo1[0], lo0[25:1], lo1[25:1]}.
  - Visible on tlb_flat_o the cycle after WRITE.
  - -> RESP.
- READ (1 cycle): from entry[idx]:
  - entryhi_o = {VPN2, 5'b0, ASID}
  - entrylo0_o = {6'b0, PFN0, C0, D0, V0, G}
  - entrylo1_o = {6'b0, PFN1, C1, D1, V1, G}
  - pagemask_o = {7'b0, Mask, 13'b0}
  - -> RESP.
- PROBE: one entry per cycle, counter 0..TLB_ENTRIES-1.
  - Match = VPN2 equal to latched hi[31:13] AND (ASID equal OR G).
  - First (lowest) match stops the scan: index_o = {1'b0, 0…, idx}.
  - No match after the last entry: index_o = 32'h8000_0000.
  - Latency from accept to resp_valid: (match idx + 2) cycles on a hit, TLB_ENTRIES+1 on a miss.
  - -> RESP.
- RESP:
  - resp_valid=1; outputs held stable until resp_ready. Then -> IDLE, resp_valid=0.
  - The next request is accepted no earlier than the cycle after the handshake.
  - Result outputs not written by the op hold zero.
- Array is written only in WRITE (or TLBWR). READ/PROBE use array contents as of that cycle.
- Reset (async, any state, including mid-PROBE or RESP):
  - state=IDLE, req_ready=1, resp_valid=0, resp_op=0.
  - All result outputs 0; all entries 0, so tlb_flat_o=0.
  - Any in-flight op is discarded.
- Index bits above IDX_W are ignored (index_i=17 with 16 entries writes entry 1).

Optional Feature:
- Macro TLB_RANDOM_EN.
- Defined:
  - Internal Random counter, IDX_W bits. Reset to TLB_ENTRIES-1. Decrements every cycle, wraps 0 -> TLB_ENTRIES-1.
  - req_op 00 = TLBWR: Random is latched at accept and written as in WRITE; response index_o = latched Random.
- Not defined:
  - No counter; op 00 is NOP with an all-zero response and no array change.

Test Plan:
- Reset, then TLBWI: index_i=3, hi=32'h0040_2005, lo0=32'h0000_1047, lo1=32'h0000_1087, pm=0. After handshake, tlb_flat_o entry 3 = {19'h00201, 8'h05, 12'h0, 1'b1, 20'h00041, 5'b00011, 20'h00042, 5'b00011}.
- TLBR index 3 after the above -> entryhi_o=32'h0040_2005, entrylo0_o=32'h0000_1047, entrylo1_o=32'h0000_1087, pagemask_o=0.
- TLBP hi=32'h0040_2009 (ASID mismatch, G=1) -> index_o=3, resp_valid 5 cycles after accept. TLBP hi=32'h0080_0005 -> index_o=32'h8000_0000 after 17 cycles.
- Entries 2 and 5 both match -> index_o=2. Hold resp_ready=0 for 4 cycles -> outputs stable, req_ready=0 throughout.
- Assert rst during PROBE cycle 6 -> resp_valid=0 and tlb_flat_o=0 immediately. A following TLBP on hi=0 (ASID 0) hits index 0.
- TLB_RANDOM_EN: issue op 00 at cycle 20 after reset -> Random=(15-20) mod 16=11, entry 11 written, index_o=11. Without the macro -> no entry changes.
